// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the RAM's second read port (addr2/out2) and its single
// write port between two requesters. m0 is the core load/store unit and m1
// is the program loader / debug master.
//
// Every transaction takes a fixed IDLE -> ISSUE -> RESP sequence:
//   IDLE  : pick a winner, pulse its gnt and latch its request.
//   ISSUE : drive the latched request to the RAM. The RAM writes and
//           samples out2 at the end of this cycle.
//   RESP  : return out2 to the winner with a one-cycle rvalid.
// Acceptance in cycle N gives rvalid in cycle N+2. The next acceptance can
// happen in cycle N+3.
//
// Handshake: a requester holds req (and its mode/addr/wdata) until it sees
// gnt, which is a one-cycle pulse in the acceptance cycle. rvalid is a
// one-cycle pulse two cycles later. There is no backpressure on rvalid.
//
// When both ports request together, the port that was not granted last
// wins. last_q holds the last winner (0 = m0, 1 = m1).
//
// Optional feature (macro RAM_ARBITER_ALIGN_CHECK_EN): adds m0_err/m1_err.
// A misaligned half or word write is still granted, but it is suppressed at
// the RAM. Its response carries err=1 and rdata=0.
//
// Ports:
//   clk, rst                     clock and synchronous active-high reset
//   mX_req/write_mode/addr/wdata request from port X (00 rd, 01 b, 10 h, 11 w)
//   mX_gnt, mX_rvalid, mX_rdata  accept pulse, response pulse, read data
//   mX_err                       misaligned-write flag (optional feature only)
//   ram_addr, ram_write_*        to the RAM addr2 and write port
//   ram_rdata                    from the RAM out2
// Internal state is visible as state_q (enum state_e) for debug binding.
module ram_arbiter #(
    parameter int XLEN       = 32,
    parameter bit RESET_LAST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            m0_req,
    input  logic [1:0]      m0_write_mode,
    input  logic [XLEN-1:0] m0_addr,
    input  logic [XLEN-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [XLEN-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic [1:0]      m1_write_mode,
    input  logic [XLEN-1:0] m1_addr,
    input  logic [XLEN-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [XLEN-1:0] m1_rdata,
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
    output logic            m0_err,
    output logic            m1_err,
`endif
    output logic [XLEN-1:0] ram_addr,
    output logic [1:0]      ram_write_mode,
    output logic [XLEN-1:0] ram_write_addr,
    output logic [XLEN-1:0] ram_write_data,
    input  logic [XLEN-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              id_q, id_d;
    logic [1:0]        mode_q, mode_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    logic              win_m1;
    logic              accept;
    logic              misalign;

    // With both ports requesting, the one not granted last wins.
    assign win_m1 = (m0_req && m1_req) ? ~last_q : m1_req;
    assign accept = (state_q == IDLE) && !rst && (m0_req || m1_req);

`ifdef RAM_ARBITER_ALIGN_CHECK_EN
    assign misalign = ((mode_q == 2'b10) && addr_q[0]) ||
                      ((mode_q == 2'b11) && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // The address and data registers only change at acceptance, so the
    // RAM side holds its last value outside ISSUE without extra muxing.
    assign ram_addr       = addr_q;
    assign ram_write_addr = addr_q;
    assign ram_write_data = wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= RESET_LAST;
            id_q    <= 1'b0;
            mode_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            mode_q  <= mode_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    last_d  = win_m1;
                    id_d    = win_m1;
                    mode_d  = win_m1 ? m1_write_mode : m0_write_mode;
                    addr_d  = win_m1 ? m1_addr       : m0_addr;
                    wdata_d = win_m1 ? m1_wdata      : m0_wdata;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Everything is gated by rst, so a reset in ISSUE or RESP
    // suppresses the write and the response in that same cycle.
    always_comb begin
        m0_gnt         = 1'b0;
        m1_gnt         = 1'b0;
        m0_rvalid      = 1'b0;
        m1_rvalid      = 1'b0;
        m0_rdata       = '0;
        m1_rdata       = '0;
        ram_write_mode = 2'b00;
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
        m0_err         = 1'b0;
        m1_err         = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    m0_gnt = ~win_m1;
                    m1_gnt = win_m1;
                end
            end
            ISSUE: begin
                if (!rst && !misalign) begin
                    ram_write_mode = mode_q;
                end
            end
            RESP: begin
                if (!rst) begin
                    if (id_q) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = misalign ? '0 : ram_rdata;
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
                        m1_err    = misalign;
`endif
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = misalign ? '0 : ram_rdata;
`ifdef RAM_ARBITER_ALIGN_CHECK_EN
                        m0_err    = misalign;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the RAM's second read port (addr2/out2) and its single write port between two requesters.
- Port m0 is the core load/store unit; port m1 is the program loader/debug master.
- Fair round-robin arbitration with a fixed 3-state sequence per transaction.
- Returns read data, or a write-completion ack, to the winning requester.

Parameters:
- XLEN, 32, address/data width in bits; must match the RAM.
- RESET_LAST, 1, initial value of the last-granted pointer, so m0 wins the first tie.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  m0 request; held until m0_gnt
- m0_write_mode  in  2  00 read, 01 byte write, 10 half write, 11 word write
- m0_addr  in  XLEN  byte address
- m0_wdata  in  XLEN  write data, little-endian lanes
- m0_gnt  out  1  request accepted (1-cycle pulse)
- m0_rvalid  out  1  response valid (1-cycle pulse)
- m0_rdata  out  XLEN  read data, 4 bytes starting at m0_addr
- m1_req, m1_write_mode, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0
- ram_addr  out  XLEN  to RAM addr2
- ram_write_mode  out  2  to RAM write_mode
- ram_write_addr  out  XLEN  to RAM write_addr
- ram_write_data  out  XLEN  to RAM write_data
- ram_rdata  in  XLEN  from RAM out2

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- States are IDLE, ISSUE and RESP. Reset enters IDLE.
- Reset values: all gnt/rvalid outputs 0; rdata 0; ram_write_mode 00; ram_addr, ram_write_addr and ram_write_data 0; last-granted pointer = RESET_LAST.
- IDLE:
  - If any req is high, pick a winner and pulse its gnt combinationally in this cycle.
  - Latch the winner's id, write_mode, addr and wdata; go to ISSUE.
  - With no req, stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port not granted last wins. Update the pointer at acceptance.
- ISSUE (1 cycle):
  - ram_addr and ram_write_addr = latched addr.
  - ram_write_mode = latched mode; ram_write_data = latched wdata.
  - The RAM performs the write and samples out2 at the end of this cycle. Go to RESP.
- RESP (1 cycle):
  - Winner's rvalid = 1 and rdata = ram_rdata. The other port's rvalid stays 0.
  - Go to IDLE.
  - For writes, rdata is the pre-write content (the RAM reads before its write commits). It is an ack only; the bench treats the value as don't-care.
- ram_write_mode is 00 in every state except ISSUE, and is forced to 00 in any cycle rst is high.
- ram_addr and the data outputs hold their last value outside ISSUE.
- Latency: acceptance in cycle N gives rvalid in cycle N+2. The next acceptance is possible in cycle N+3, so throughput is 1 transaction per 3 cycles.
- A requester may raise req again in its rvalid cycle; it is considered in the following IDLE cycle.
- Boundary cases:
  - req dropped before gnt: no transaction.
  - A req change while the arbiter is busy has no effect until IDLE.
  - Address wrap is the RAM's concern; addr is passed through unmodified.
  - rst in ISSUE or RESP: the transaction is aborted, no rvalid is issued, and no write occurs in a cycle with rst high. The next cycle is IDLE.
  - rst and req in the same cycle: no gnt.

Optional Feature:
- Macro RAM_ARBITER_ALIGN_CHECK_EN adds ports m0_err and m1_err (out, 1 bit), both reset to 0.
- With the macro:
  - A write with mode 10 and addr[0]=1, or mode 11 and addr[1:0]!=0, is misaligned.
  - A misaligned write is still granted, but ISSUE drives ram_write_mode 00 (no write).
  - In RESP the winner gets rvalid=1, rdata=0 and err=1.
  - Reads (mode 00) and byte writes are never flagged.
- Without the macro: no err ports, and all accesses pass to the RAM unchanged.

Test Plan:
- m0 word write 0xDEADBEEF @0x100 (gnt cycle N), then m0 read @0x100 -> read rvalid at its gnt+2, rdata 0xDEADBEEF; ram_write_mode=11 only in cycle N+1.
- m0 and m1 both request reads in the same cycle after reset -> m0 gnt first, m1 gnt 3 cycles later; repeat both -> m0 again (alternation holds).
- m1 byte write 0x5A @0x203 over word 0x11223344 @0x200 -> read @0x200 returns 0x5A223344.
- Assert rst during ISSUE of an m0 word write @0x40 -> no rvalid; next read @0x40 returns the prior value; ram_write_mode never 11 while rst is high.
- m1 holds req continuously while m0 is idle -> m1 gnt every 3 cycles, rvalid 2 cycles after each gnt.
- With RAM_ARBITER_ALIGN_CHECK_EN, m0 half write @0x101 -> m0_rvalid with m0_err=1, rdata 0, memory unchanged; half write @0x102 -> err=0.
